// File: rtl/aes_pkg.sv
// Shared defaults, tag record and FSM encoding for the AES pipeline arbiter.
package aes_pkg;

  localparam int DEF_BLOCK_LENGTH = 128;
  localparam int DEF_PIPE_DEPTH   = 10;
  localparam int DEF_OUT_DEPTH    = 16;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/aes_out_fifo.sv
// Synchronous FIFO with occupancy count; head is visible the cycle after its push edge.
// No overflow guard: the upstream credit scheme never pushes into a full FIFO.
module aes_out_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic                         head_valid,
  output logic [WIDTH-1:0]             head_data,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign head_valid = (count != '0);
  assign do_pop     = pop & head_valid;
  // Storage is not reset, so the head is masked to keep out_data at zero when empty.
  assign head_data  = head_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_pipe_arbiter.sv
// Round-robin issue of two requesters into a shared pipelined AES core, results buffered by credit.
// Optional per-requester accept counters are built when AES_ARB_STATS_EN is defined.
module aes_pipe_arbiter
  import aes_pkg::*;
#(
  parameter int BLOCK_LENGTH = DEF_BLOCK_LENGTH,
  parameter int PIPE_DEPTH   = DEF_PIPE_DEPTH,
  parameter int OUT_DEPTH    = DEF_OUT_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  input  logic [BLOCK_LENGTH-1:0] req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [BLOCK_LENGTH-1:0] req1_data,
  output logic                    req1_ready,
  output logic                    core_in_valid,
  output logic [BLOCK_LENGTH-1:0] core_in_data,
  input  logic [BLOCK_LENGTH-1:0] core_out_data,
  output logic                    out_valid,
  output logic [BLOCK_LENGTH-1:0] out_data,
  output logic                    out_id,
  input  logic                    out_ready,
  input  logic                    flush,
`ifdef AES_ARB_STATS_EN
  output logic [31:0]             stat_cnt0,
  output logic [31:0]             stat_cnt1,
`endif
  output logic                    flush_done
);

  localparam int CW = $clog2(OUT_DEPTH+1);

  state_t            state;
  state_t            state_nxt;
  logic              rr_ptr;
  tag_t              tags [PIPE_DEPTH+1];
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [CW:0]       used;
  logic              credit_ok;
  logic              grant0;
  logic              grant1;
  logic              run_ok;
  logic              accept0;
  logic              accept1;
  logic              accept;
  logic              fifo_push;
  logic              fifo_pop;
  logic [BLOCK_LENGTH:0] fifo_head;

  // tags[0] sits alongside the core input register, tags[PIPE_DEPTH] alongside core_out_data.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= PIPE_DEPTH; i++) begin
      inflight = inflight + CW'(tags[i].valid);
    end
  end

  assign used      = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok = (used < (CW+1)'(OUT_DEPTH));

  assign grant0 = req0_valid & (~req1_valid | ~rr_ptr);
  assign grant1 = req1_valid & (~req0_valid |  rr_ptr);
  // rst gates the readies so they read 0 while reset is held, whatever the requesters drive.
  assign run_ok = (state == RUN) & credit_ok & rst;

  assign req0_ready = grant0 & run_ok;
  assign req1_ready = grant1 & run_ok;
  assign accept0    = req0_valid & req0_ready;
  assign accept1    = req1_valid & req1_ready;
  assign accept     = accept0 | accept1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_in_valid <= 1'b0;
      core_in_data  <= '0;
      rr_ptr        <= 1'b0;
    end else begin
      core_in_valid <= accept;
      if (accept) begin
        core_in_data <= accept1 ? req1_data : req0_data;
      end
      if (accept0) begin
        rr_ptr <= 1'b1;
      end else if (accept1) begin
        rr_ptr <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i <= PIPE_DEPTH; i++) begin
        tags[i] <= '0;
      end
    end else begin
      tags[0] <= '{valid: accept, id: accept1};
      for (int i = 1; i <= PIPE_DEPTH; i++) begin
        tags[i] <= tags[i-1];
      end
    end
  end

  assign fifo_push = tags[PIPE_DEPTH].valid;
  assign fifo_pop  = out_valid & out_ready;

  aes_out_fifo #(
    .WIDTH (BLOCK_LENGTH + 1),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (fifo_push),
    .push_data  ({tags[PIPE_DEPTH].id, core_out_data}),
    .pop        (fifo_pop),
    .head_valid (out_valid),
    .head_data  (fifo_head),
    .count      (fifo_count)
  );

  assign out_data = fifo_head[BLOCK_LENGTH-1:0];
  assign out_id   = fifo_head[BLOCK_LENGTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      RUN: begin
        if (flush) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!flush) begin
          state_nxt = RUN;
        end else if (inflight == '0 && fifo_count == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        flush_done = 1'b1;
        if (!flush) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

`ifdef AES_ARB_STATS_EN
  logic enter_done;
  assign enter_done = (state != DONE) && (state_nxt == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else if (enter_done) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else begin
      stat_cnt0 <= stat_cnt0 + 32'(accept0);
      stat_cnt1 <= stat_cnt1 + 32'(accept1);
    end
  end
`endif

endmodule
